bs_responder: RTL and testbench

- Responder end of the backing-store request/done protocol issued by the cache: a word-addressed memory with configurable fixed access latency.
- Drop-in behavioural model of the backing store behind the cache, for simulation and FPGA bring-up.
- Accepts one request at a time on a single-cycle `req_do` strobe and answers with a single-cycle `req_done` pulse carrying read data.
- Keeps saturating read/write counters for debug.

---
 rtl/bs_responder_pkg.sv | 28 ++
 rtl/bs_responder_if.sv | 30 +++
 rtl/bs_mem_array.sv | 53 +++++
 rtl/bs_responder.sv | 127 ++++++++++++
 tb/tb_bs_responder.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bs_responder_pkg.sv
//------------------------------------------------------------------------------
// Module   : bs_responder_pkg
// Summary  : Shared backing-store request types, responder states and defaults.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bs_responder_pkg;

  typedef enum logic {
    BackingStoreRead  = 1'b0,
    BackingStoreWrite = 1'b1
  } bs_req_type_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  localparam int BS_DEFAULT_LATENCY = 4;

  // Byte address to word address; the caller keeps only the bits it indexes with.
  function automatic logic [31:0] bs_word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bs_responder_if.sv
//------------------------------------------------------------------------------
// Module   : bs_responder_if
// Summary  : Request/done handshake between the cache and the backing store.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bs_responder_if;
  import bs_responder_pkg::*;

  logic [31:0]  req_addr;
  logic [31:0]  req_data;
  bs_req_type_e req_type;
  logic         req_do;
  logic [31:0]  O_data;
  logic         req_done;

  modport master (
    output req_addr, req_data, req_type, req_do,
    input  O_data, req_done
  );

  modport slave (
    input  req_addr, req_data, req_type, req_do,
    output O_data, req_done
  );

endinterface

`default_nettype wire

// File: rtl/bs_mem_array.sv
//------------------------------------------------------------------------------
// Module   : bs_mem_array
// Summary  : 2^ADDR_BITS x 32 word array, async clear, one write and one registered read port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bs_mem_array #(
  parameter int ADDR_BITS = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 wr_en,
  input  wire logic [ADDR_BITS-1:0] wr_idx,
  input  wire logic [31:0]          wr_data,
  input  wire logic                 rd_en,
  input  wire logic [ADDR_BITS-1:0] rd_idx,
  output logic      [31:0]          rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_d;
  logic [31:0] rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  // The whole-array clear becomes a sweep once this maps onto block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/bs_responder.sv
//------------------------------------------------------------------------------
// Module   : bs_responder
// Summary  : Fixed-latency backing-store responder with saturating debug counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bs_responder
  import bs_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = BS_DEFAULT_LATENCY
) (
  input  wire logic    clk,
  input  wire logic    reset,
  bs_responder_if.slave bus,
  output logic [15:0]  stat_reads,
  output logic [15:0]  stat_writes
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $fatal(1, "bs_responder: LATENCY must be in 1..255");
  end

  logic [1:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          data_q, data_d;
  bs_req_type_e         type_q, type_d;
  logic [15:0]          stat_reads_q, stat_reads_d;
  logic [15:0]          stat_writes_q, stat_writes_d;

  logic [31:0] word_addr;
  logic        unused_addr_bits;
  logic        access;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        respond;

  assign word_addr        = bs_word_addr(bus.req_addr);
  assign unused_addr_bits = ^word_addr[31:ADDR_BITS];

  // The access itself happens on the last WAIT edge so RESPOND sees registered data.
  assign access    = (state_q == ST_WAIT) && (cnt_q == 8'd0);
  assign mem_wr_en = access && (type_q == BackingStoreWrite);
  assign mem_rd_en = access && (type_q == BackingStoreRead);
  assign respond   = (state_q == ST_RESPOND);

  bs_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_wr_en),
    .wr_idx  (idx_q),
    .wr_data (data_q),
    .rd_en   (mem_rd_en),
    .rd_idx  (idx_q),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    data_d        = data_q;
    type_d        = type_q;
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_do) begin
          idx_d   = word_addr[ADDR_BITS-1:0];
          data_d  = bus.req_data;
          type_d  = bus.req_type;
          cnt_d   = 8'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (type_q == BackingStoreRead) begin
          if (stat_reads_q != 16'hFFFF) stat_reads_d = stat_reads_q + 16'd1;
        end else begin
          if (stat_writes_q != 16'hFFFF) stat_writes_d = stat_writes_q + 16'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      type_q        <= BackingStoreRead;
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      type_q        <= type_d;
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign bus.req_done = respond;
  assign bus.O_data   = (respond && (type_q == BackingStoreRead)) ? mem_rd_data : 32'd0;
  assign stat_reads   = stat_reads_q;
  assign stat_writes  = stat_writes_q;

endmodule

`default_nettype wire

// File: tb/tb_bs_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_bs_responder
// Summary  : Directed self-checking bench for bs_responder at LATENCY 4, 1 and 7.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bs_responder;
  import bs_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bs_responder_if bus4 ();
  bs_responder_if bus1 ();
  bs_responder_if bus7 ();

  // The short- and long-latency instances see the same request stream.
  assign bus1.req_addr = bus4.req_addr;
  assign bus1.req_data = bus4.req_data;
  assign bus1.req_type = bus4.req_type;
  assign bus1.req_do   = bus4.req_do;
  assign bus7.req_addr = bus4.req_addr;
  assign bus7.req_data = bus4.req_data;
  assign bus7.req_type = bus4.req_type;
  assign bus7.req_do   = bus4.req_do;

  logic [15:0] sr4, sw4, sr1, sw1, sr7, sw7;

  bs_responder #(.ADDR_BITS(8), .LATENCY(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus4), .stat_reads(sr4), .stat_writes(sw4));
  bs_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .bus(bus1), .stat_reads(sr1), .stat_writes(sw1));
  bs_responder #(.ADDR_BITS(8), .LATENCY(7)) u_dut_l7 (
    .clk(clk), .reset(reset), .bus(bus7), .stat_reads(sr7), .stat_writes(sw7));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bs_req_type_e t);
    bus4.req_addr = a;
    bus4.req_data = d;
    bus4.req_type = t;
    bus4.req_do   = 1'b1;
    step();
    bus4.req_do   = 1'b0;
    bus4.req_addr = $urandom;
    bus4.req_data = $urandom;
    bus4.req_type = (t == BackingStoreRead) ? BackingStoreWrite : BackingStoreRead;
  endtask

  // Request on the LATENCY=4 instance: done exactly 5 cycles later, then one idle cycle.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input bs_req_type_e t,
                        input logic [31:0] exp_rd, input string tag);
    issue(a, d, t);
    for (int k = 1; k <= 5; k++) begin
      chk({tag, "_done"}, {31'd0, bus4.req_done}, {31'd0, (k == 5)});
      chk({tag, "_data"}, bus4.O_data, (k == 5) ? exp_rd : 32'd0);
      if (k < 5) step();
    end
    step();
    chk({tag, "_after"}, {31'd0, bus4.req_done}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus4.req_addr = '0;
    bus4.req_data = '0;
    bus4.req_type = BackingStoreRead;
    bus4.req_do   = 1'b0;
    #12;
    chk("rst_done",   {31'd0, bus4.req_done}, 32'd0);
    chk("rst_odata",  bus4.O_data, 32'd0);
    chk("rst_reads",  {16'd0, sr4}, 32'd0);
    chk("rst_writes", {16'd0, sw4}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Latency sweep plus reset contents: read index 255 issued in cycle 10.
    while (cyc < 10) step();
    issue(32'h0000_03FC, 32'h0, BackingStoreRead);
    while (cyc <= 19) begin
      chk("sweep_l1_done", {31'd0, bus1.req_done}, {31'd0, (cyc == 12)});
      chk("sweep_l7_done", {31'd0, bus7.req_done}, {31'd0, (cyc == 18)});
      chk("sweep_l4_done", {31'd0, bus4.req_done}, {31'd0, (cyc == 15)});
      chk("sweep_l4_data", bus4.O_data, 32'd0);
      step();
    end
    chk("rstmem_reads",  {16'd0, sr4}, 32'd1);
    chk("rstmem_writes", {16'd0, sw4}, 32'd0);
    chk("l7_reads",      {16'd0, sr7}, 32'd1);

    // Round trip, with the read issued the cycle after the write's done.
    do_req(32'h0000_0010, 32'hCAFE_F00D, BackingStoreWrite, 32'h0, "rt_wr");
    do_req(32'h0000_0010, 32'h0,         BackingStoreRead,  32'hCAFE_F00D, "rt_rd");

    // High address bits and byte offset are ignored.
    do_req(32'h1234_0404, 32'h1111_2222, BackingStoreWrite, 32'h0, "alias_wr");
    do_req(32'h0000_0004, 32'h0,         BackingStoreRead,  32'h1111_2222, "alias_rd");

    // Busy rejection: a write strobed during WAIT must vanish.
    issue(32'h0000_0010, 32'h0, BackingStoreRead);
    bus4.req_addr = 32'h0000_0080;
    bus4.req_data = 32'hFFFF_FFFF;
    bus4.req_type = BackingStoreWrite;
    bus4.req_do   = 1'b1;
    chk("busy_done_k1", {31'd0, bus4.req_done}, 32'd0);
    step();
    bus4.req_do = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      chk("busy_done", {31'd0, bus4.req_done}, {31'd0, (k == 5)});
      chk("busy_data", bus4.O_data, (k == 5) ? 32'hCAFE_F00D : 32'd0);
      if (k < 5) step();
    end
    for (int k = 0; k < 6; k++) begin
      step();
      chk("busy_no_extra", {31'd0, bus4.req_done}, 32'd0);
    end
    do_req(32'h0000_0080, 32'h0, BackingStoreRead, 32'h0, "busy_b_rd");
    chk("stat_reads",  {16'd0, sr4}, 32'd5);
    chk("stat_writes", {16'd0, sw4}, 32'd2);

    // Reset two cycles into a write aborts it.
    issue(32'h0000_0020, 32'hAAAA_5555, BackingStoreWrite);
    step();
    reset = 1'b1;
    #2;
    chk("midrst_reads",  {16'd0, sr4}, 32'd0);
    chk("midrst_writes", {16'd0, sw4}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("midrst_no_done", {31'd0, bus4.req_done}, 32'd0);
      step();
    end
    do_req(32'h0000_0020, 32'h0, BackingStoreRead, 32'h0, "midrst_rd");
    chk("midrst_reads_after",  {16'd0, sr4}, 32'd1);
    chk("midrst_writes_after", {16'd0, sw4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
